// File: rtl/spi_flash_arbiter.sv
// Two-port SPI flash read arbiter: port A fetches 16-bit words, port B 8-bit bytes,
// each as one 0x03 READ (mode 0, single I/O) with round-robin arbitration.
// Ports:
//   clk, rst                  clock, async active-high reset
//   a_req/a_addr/a_ack/a_rdata  word port (first flash byte in [15:8])
//   b_req/b_addr/b_ack/b_rdata  byte port
//   busy                      high from grant through the ack cycle
//   spi_cs/spi_sclk/spi_io*   SPI pins (io0 = MOSI, io1 = MISO)
module spi_flash_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int CLK_DIV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_ack,
   output logic [15:0]       a_rdata,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   output logic              b_ack,
   output logic [7:0]        b_rdata,
   output logic              busy,
   output logic              spi_cs,
   output logic              spi_sclk,
   output logic              spi_io0_o,
   output logic              spi_io0_oe,
   output logic              spi_io1_o,
   output logic              spi_io1_oe,
   input  logic              spi_io1_i
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, GRANT, SHIFT, DONE} state_t;

   state_t        state;
   logic          last_b;
   logic          sel_a;
   logic [30:0]   sr;
   logic [15:0]   rx;
   logic [5:0]    bit_cnt;
   logic [DW-1:0] div;
   logic          high;

   logic          pick_a;
   logic [23:0]   a_ext;
   logic [23:0]   b_ext;
   logic [31:0]   cmd;
   logic [5:0]    last_bit;

   assign spi_io0_oe = 1'b1;
   assign spi_io1_o  = 1'b0;
   assign spi_io1_oe = 1'b0;

   // A wins a tie only when B was served last.
   assign pick_a   = a_req & (~b_req | last_b);
   assign last_bit = sel_a ? 6'd47 : 6'd39;

   always_comb begin
      a_ext = '0;
      b_ext = '0;
      a_ext[ADDR_W-1:0] = a_addr;
      b_ext[ADDR_W-1:0] = b_addr;
      cmd = {8'h03, pick_a ? a_ext : b_ext};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         last_b    <= 1'b1;
         sel_a     <= 1'b0;
         sr        <= '0;
         rx        <= '0;
         bit_cnt   <= '0;
         div       <= '0;
         high      <= 1'b0;
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         a_rdata   <= '0;
         b_rdata   <= '0;
         busy      <= 1'b0;
         spi_cs    <= 1'b1;
         spi_sclk  <= 1'b0;
         spi_io0_o <= 1'b0;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (a_req | b_req) begin
                  state <= GRANT;
                  busy  <= 1'b1;
               end
            end
            GRANT: begin
               sel_a     <= pick_a;
               last_b    <= ~pick_a;
               // io0 carries the first command bit; sr holds the rest.
               spi_io0_o <= cmd[31];
               sr        <= cmd[30:0];
               bit_cnt   <= '0;
               div       <= '0;
               high      <= 1'b0;
               spi_cs    <= 1'b0;
               spi_sclk  <= 1'b0;
               state     <= SHIFT;
            end
            SHIFT: begin
               if (div == DIV_MAX) begin
                  div <= '0;
                  if (!high) begin
                     // Rising sclk: sample MISO on this edge.
                     high     <= 1'b1;
                     spi_sclk <= 1'b1;
                     rx       <= {rx[14:0], spi_io1_i};
                  end else begin
                     high     <= 1'b0;
                     spi_sclk <= 1'b0;
                     sr       <= {sr[29:0], 1'b0};
                     if (bit_cnt == last_bit) begin
                        state     <= DONE;
                        spi_cs    <= 1'b1;
                        spi_io0_o <= 1'b0;
                        if (sel_a) begin
                           a_ack   <= 1'b1;
                           a_rdata <= rx;
                        end else begin
                           b_ack   <= 1'b1;
                           b_rdata <= rx[7:0];
                        end
                     end else begin
                        bit_cnt   <= bit_cnt + 6'd1;
                        // MOSI idles low once the 32 command bits are out.
                        spi_io0_o <= (bit_cnt < 6'd31) ? sr[30] : 1'b0;
                     end
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: SPI flash models, directed scenarios and random reads
// checked against latency/data/arbitration rules computed from a memory image.
module tb_spi_flash_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [256];

   // DUT with CLK_DIV=1
   logic        a_req, b_req, a_ack, b_ack, busy;
   logic [15:0] a_addr, b_addr, a_rdata;
   logic [7:0]  b_rdata;
   logic        cs0, sclk0, mosi0, oe0, o1_0, oe1_0;
   logic        miso0 = 1'b0;

   // DUT with CLK_DIV=3 (port A only)
   logic        a_req3, b_req3, a_ack3, b_ack3, busy3;
   logic [15:0] a_addr3, b_addr3, a_rdata3;
   logic [7:0]  b_rdata3;
   logic        cs3, sclk3, mosi3, oe3, o1_3, oe1_3;
   logic        miso3 = 1'b0;

   spi_flash_arbiter #(.ADDR_W(16), .CLK_DIV(1)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_rdata(b_rdata),
      .busy(busy), .spi_cs(cs0), .spi_sclk(sclk0),
      .spi_io0_o(mosi0), .spi_io0_oe(oe0),
      .spi_io1_o(o1_0), .spi_io1_oe(oe1_0), .spi_io1_i(miso0)
   );

   spi_flash_arbiter #(.ADDR_W(16), .CLK_DIV(3)) dut3 (
      .clk(clk), .rst(rst),
      .a_req(a_req3), .a_addr(a_addr3), .a_ack(a_ack3), .a_rdata(a_rdata3),
      .b_req(b_req3), .b_addr(b_addr3), .b_ack(b_ack3), .b_rdata(b_rdata3),
      .busy(busy3), .spi_cs(cs3), .spi_sclk(sclk3),
      .spi_io0_o(mosi3), .spi_io0_oe(oe3),
      .spi_io1_o(o1_3), .spi_io1_oe(oe1_3), .spi_io1_i(miso3)
   );

   // Flash data bit n (n >= 32) of a READ whose command word is c.
   function automatic logic fbit(input logic [31:0] c, input int n);
      logic [23:0] a;
      int k;
      k = n - 32;
      a = c[23:0] + 24'(k / 8);
      return mem[a[7:0]][7 - (k % 8)];
   endfunction

   int          f0_cnt = 0;
   logic [31:0] f0_cmd = '0;
   always @(posedge sclk0 or posedge cs0)
      if (cs0) f0_cnt <= 0;
      else begin
         if (f0_cnt < 32) f0_cmd <= {f0_cmd[30:0], mosi0};
         f0_cnt <= f0_cnt + 1;
      end
   always @(negedge sclk0)
      if (!cs0 && f0_cnt >= 32) miso0 <= fbit(f0_cmd, f0_cnt);

   int          f3_cnt = 0;
   logic [31:0] f3_cmd = '0;
   always @(posedge sclk3 or posedge cs3)
      if (cs3) f3_cnt <= 0;
      else begin
         if (f3_cnt < 32) f3_cmd <= {f3_cmd[30:0], mosi3};
         f3_cnt <= f3_cnt + 1;
      end
   always @(negedge sclk3)
      if (!cs3 && f3_cnt >= 32) miso3 <= fbit(f3_cmd, f3_cnt);

   // CS high-gap monitor on dut
   int cs_run = 0, bad_gaps = 0, cs_falls = 0;
   always @(negedge clk) begin
      if (cs0) cs_run++;
      else begin
         if (cs_run > 0) begin
            cs_falls++;
            if (cs_run < 2) bad_gaps++;
         end
         cs_run = 0;
      end
   end

   // sclk half-period monitor on dut3
   int   h_run = 0, bad_half = 0, halves = 0;
   logic p_cs = 1'b1, p_sclk = 1'b0;
   always @(negedge clk) begin
      if (!cs3) begin
         if (!p_cs) begin
            if (sclk3 == p_sclk) h_run++;
            else begin
               if (h_run != 3) bad_half++;
               halves++;
               h_run = 1;
            end
         end else h_run = 1;
      end
      p_cs   = cs3;
      p_sclk = sclk3;
   end

   int tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Returns the cycle of the ack pulse (port 0=A,1=B,2=either), -1 on timeout.
   task automatic wait_ack(input int port, input int limit, output int at, output int who);
      at  = -1;
      who = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if ((port != 1) && a_ack) begin at = cyc; who = 0; return; end
         if ((port != 0) && b_ack) begin at = cyc; who = 1; return; end
      end
   endtask

   function automatic logic [15:0] exp_word(input logic [15:0] a);
      logic [7:0] n;
      n = a[7:0] + 8'd1;
      return {mem[a[7:0]], mem[n]};
   endfunction

   function automatic int lat(input bit is_a, input int d);
      return 2 + (32 + (is_a ? 16 : 8)) * 2 * d;
   endfunction

   initial begin
      int t0, at, who, exp_port, ref_last, g0;
      logic [15:0] pa, pb;
      logic [15:0] last_a;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h10] = 8'hA5;
      mem[8'h11] = 8'h3C;
      mem[8'hFF] = 8'h7E;
      rst = 1'b1;
      a_req = 0; b_req = 0; a_addr = '0; b_addr = '0;
      a_req3 = 0; b_req3 = 0; a_addr3 = '0; b_addr3 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs", cs0, 1);
      chk("rst_sclk", sclk0, 0);
      chk("rst_mosi", mosi0, 0);
      chk("rst_acks", {a_ack, b_ack, busy}, 0);
      chk("rst_rdata", {a_rdata, b_rdata}, 0);
      chk("const_oe", {oe0, o1_0, oe1_0}, 3'b100);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // 1: A read at 0x0010
      #1 a_addr = 16'h0010; a_req = 1; t0 = cyc;
      wait_ack(0, 400, at, who);
      chk("t1_lat", at - t0, 98);
      chk("t1_data", a_rdata, 16'hA53C);
      chk("t1_cmd", f0_cmd, 32'h03000010);
      chk("t1_busy", busy, 1);
      @(posedge clk); #1 a_req = 0;
      repeat (2) @(posedge clk);

      // 2: B read at 0x00FF
      #1 b_addr = 16'h00FF; b_req = 1; t0 = cyc;
      wait_ack(1, 400, at, who);
      chk("t2_lat", at - t0, 82);
      chk("t2_data", b_rdata, 8'h7E);
      chk("t2_a_hold", a_rdata, 16'hA53C);
      chk("t2_cmd", f0_cmd, 32'h030000FF);
      @(posedge clk); #1 b_req = 0;

      // 3: both held after reset -> A,B,A,B
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      g0 = bad_gaps;
      pa = 16'($urandom); pb = 16'($urandom);
      a_addr = pa; b_addr = pb; a_req = 1; b_req = 1;
      ref_last = 1;
      for (int i = 0; i < 4; i++) begin
         exp_port = (ref_last == 1) ? 0 : 1;
         ref_last = exp_port;
         wait_ack(2, 300, at, who);
         chk("t3_order", who, exp_port);
         if (exp_port == 0) chk("t3_adata", a_rdata, exp_word(pa));
         else chk("t3_bdata", b_rdata, {8'h0, mem[pb[7:0]]});
      end
      @(posedge clk); #1 a_req = 0; b_req = 0;
      repeat (2) @(posedge clk);
      chk("t3_gap", bad_gaps - g0, 0);

      // 4: A arrives 40 cycles into a B read
      #1 pb = 16'($urandom); pa = 16'($urandom);
      b_addr = pb; b_req = 1; t0 = cyc;
      repeat (40) @(posedge clk);
      #1 a_addr = pa; a_req = 1;
      wait_ack(2, 300, at, who);
      chk("t4_first", who, 1);
      chk("t4_blat", at - t0, 82);
      chk("t4_bdata", b_rdata, {8'h0, mem[pb[7:0]]});
      t0 = at + 1;
      @(posedge clk); #1 b_req = 0;
      wait_ack(0, 300, at, who);
      chk("t4_alat", at - t0, 98);
      chk("t4_adata", a_rdata, exp_word(pa));
      @(posedge clk); #1 a_req = 0;
      repeat (2) @(posedge clk);

      // 5: reset 20 cycles into SHIFT, A held
      #1 pa = 16'($urandom); a_addr = pa; a_req = 1; t0 = cyc;
      repeat (22) @(posedge clk);
      #1 chk("t5_cs_low", cs0, 0);
      rst = 1;
      #1 chk("t5_cs_now", cs0, 1);
      chk("t5_sclk_now", sclk0, 0);
      chk("t5_busy_now", busy, 0);
      chk("t5_rdata_rst", a_rdata, 0);
      at = 0;
      repeat (5) begin
         @(negedge clk);
         if (a_ack) at++;
      end
      chk("t5_no_ack", at, 0);
      @(posedge clk); #1 rst = 0; t0 = cyc;
      wait_ack(0, 300, at, who);
      chk("t5_lat", at - t0, 98);
      chk("t5_data", a_rdata, exp_word(pa));
      @(posedge clk); #1 a_req = 0;
      repeat (2) @(posedge clk);

      // random single reads, including the top address
      last_a = a_rdata;
      for (int i = 0; i < 10; i++) begin
         bit is_a;
         logic [15:0] ad;
         is_a = ($urandom_range(0, 1) == 1) || (i == 0);
         ad = (i == 0) ? 16'hFFFF : 16'($urandom);
         #1;
         if (is_a) begin a_addr = ad; a_req = 1; end
         else begin b_addr = ad; b_req = 1; end
         t0 = cyc;
         wait_ack(is_a ? 0 : 1, 300, at, who);
         chk("rnd_lat", at - t0, lat(is_a, 1));
         chk("rnd_cmd", f0_cmd, {8'h03, 8'h00, ad});
         if (is_a) begin
            chk("rnd_adata", a_rdata, exp_word(ad));
            last_a = exp_word(ad);
         end else begin
            chk("rnd_bdata", b_rdata, {8'h0, mem[ad[7:0]]});
            chk("rnd_a_hold", a_rdata, last_a);
         end
         @(posedge clk); #1 a_req = 0; b_req = 0;
         repeat ($urandom_range(1, 3)) @(posedge clk);
      end

      // 6: CLK_DIV=3 A read
      #1 pa = 16'($urandom); a_addr3 = pa; a_req3 = 1; t0 = cyc;
      at = -1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (a_ack3) begin at = cyc; break; end
      end
      chk("t6_lat", at - t0, 290);
      chk("t6_data", a_rdata3, exp_word(pa));
      chk("t6_cmd", f3_cmd, {8'h03, 8'h00, pa});
      chk("t6_halfs", bad_half, 0);
      chk("t6_nhalf", halves, 95);
      @(posedge clk); #1 a_req3 = 0;
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
